ram_requester: RTL and testbench
================================

# ram_requester

Initiator-side controller for the CPU RAM interface. It arbitrates one instruction-fetch port and one data port onto the single `cpu_ram_if` RAM. It holds each RAM request stable until the RAM reports `ACCESS`, captures the load word, and returns a one-cycle completion pulse to the winning port. It sits between the datapath/cache request logic and the `ram` block, and is the only driver of `ramREN`, `ramWEN`, `ramaddr` and `ramstore`.

## Interface
Parameters:
- `TIMEOUT`, default 64: maximum cycles in a BUSY state before the access is aborted; must exceed the RAM latency plus 2.
- `BAD`, default 32'hBAD1BAD1: load value returned on an aborted or illegal access.

Ports (types from `cpu_types_pkg`: `word_t` is 32 bits, `ramstate_t` is FREE/BUSY/ACCESS/ERROR):
- `CLK` in 1: clock. One clock domain; all state updates on the rising edge.
- `RST` in 1: reset. Synchronous and active-high.
- `iREN` in 1: instruction read request; held by requester until `idone`.
- `iaddr` in 32: instruction word address (bits [1:0] ignored).
- `dREN` in 1: data read request; held until `ddone`.
- `dWEN` in 1: data write request; held until `ddone`.
- `daddr` in 32: data address.
- `dstore` in 32: data write value.
- `iload` out 32: registered instruction load word; valid while `idone`=1.
- `dload` out 32: registered data load word; valid while `ddone`=1.
- `idone` out 1: one-cycle completion pulse, I port.
- `ddone` out 1: one-cycle completion pulse, D port.
- `ierr` out 1: qualifies `idone`; access aborted.
- `derr` out 1: qualifies `ddone`; access aborted or illegal.
- `err_sticky` out 1: set on any abort; cleared only by `RST`.
- `ramREN` out 1: RAM read enable.
- `ramWEN` out 1: RAM write enable.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data; valid only when `ramstate`==ACCESS.
- `ramstate` in ramstate_t: RAM status.

## Operation
FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- **IDLE:** `ramREN`=`ramWEN`=0. Grant rules, evaluated on pending requests:
  - Only one port requesting: that port wins.
  - Both ports requesting: the port not granted last wins, using a `last_grant` register. `last_grant` resets to I, so D wins the first tie.
  - On grant, the winner's addr, data and direction are latched, and the FSM moves to BUSY_I or BUSY_D.
- **Illegal data request:** `dREN`=`dWEN`=1 in IDLE is illegal. The FSM goes directly to RESP with `derr`=1, `dload`=BAD and `err_sticky` set. No RAM access is made.
- **BUSY_x:** `ramaddr`, `ramstore`, `ramREN` and `ramWEN` are driven only from the latched registers. They must not change for the whole state, because the RAM restarts its latency count on any change to addr or enable.
  - `ramstore` is driven only for writes and is 0 otherwise.
  - The timeout counter clears on entry and increments every cycle.
  - On `ramstate`==ACCESS: `ramload` is captured into `iload`/`dload` (for reads), and the FSM goes to RESP.
  - On `ramstate`==ERROR, or counter==TIMEOUT-1 without ACCESS: the access is aborted. The load is set to BAD, the err flag for that port is set, `err_sticky` is set, and the FSM goes to RESP.
- **RESP:** the done pulse (and err flag, if set) is asserted for exactly 1 cycle. RAM enables are 0. `last_grant` is updated. The FSM returns to IDLE.
  - Requester drops or changes its request in the cycle after done.
  - A new request can be granted in the IDLE cycle after RESP.
- Writes: `dload` is don't-care but is driven to 0.
- Reset values: state IDLE, all outputs 0, `err_sticky`=0, `last_grant`=I.

## Timing
- Grant cycle g: the request is seen in IDLE.
- Cycles g+1 onward: RAM signals asserted.
- For a RAM of latency L and a fresh addr/direction: ACCESS is first seen in cycle g+L+2, RESP/done in cycle g+L+3, next grant possible in g+L+4.
- RAM enables are deasserted for 2 cycles (RESP, IDLE) between consecutive accesses. The RAM therefore always restarts its count, even for back-to-back accesses to the same address.
- `RST` in any state: the next cycle is IDLE with all outputs at reset values. An in-flight access produces no done pulse; the requester must reissue it.
- A request deasserted mid-BUSY is ignored. The latched access completes and the pulse is delivered anyway.

## Test plan
- **I-port read:** LAT=15, RAM word 0x40 = 32'h1234ABCD; `iREN`=1, `iaddr`=0x40 at cycle 0 -> `ramREN`=1, `ramaddr`=0x40 stable cycles 1-17; `idone`=1, `iload`=32'h1234ABCD in cycle 18 only.
- **D write then read:** LAT=15; `dWEN` to 0x100 with 32'hDEADBEEF -> `ddone` at cycle 18, `ramWEN` high 1-17; then `dREN` 0x100 -> `dload`=32'hDEADBEEF, `derr`=0.
- **Simultaneous requests:** `iREN` and `dREN` both held from reset -> D granted first, I second, then D again if still requesting (strict alternation); `ramaddr` never changes within a BUSY window.
- **Timeout:** TIMEOUT=8, RAM stuck BUSY -> `ddone`=1, `derr`=1, `dload`=32'hBAD1BAD1 at cycle 9 after grant; `err_sticky` stays 1 until `RST`.
- **Illegal request:** `dREN`=`dWEN`=1 -> no RAM enable ever asserted, `ddone`/`derr`=1 one cycle after grant cycle.
- **Reset mid-access:** `RST` at cycle 5 of an I read -> cycle 6 all outputs 0, no `idone`; after `RST` release, the reissued read completes normally.

Source files
------------

// File: rtl/ram_requester.sv
// Arbitrates the I and D ports onto one RAM; done pulses L+3 cycles after grant for a RAM of latency L.
// Requesters hold requests until their done pulse; one IDLE cycle separates RESP from the next grant.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

module ram_requester
    import cpu_types_pkg::*;
#(
    parameter int    TIMEOUT = 64,
    parameter word_t BAD     = 32'hBAD1BAD1
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output word_t     iload,
    output word_t     dload,
    output logic      idone,
    output logic      ddone,
    output logic      ierr,
    output logic      derr,
    output logic      err_sticky,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

    localparam logic [31:0] CNT_LAST = 32'(TIMEOUT - 1);

    state_t      state;
    logic        last_grant;   // 0 = I port, 1 = D port
    logic        cur_grant;
    logic [31:0] cnt;
    logic        d_req;
    logic        grant_d;
    logic        hit;
    logic        finish;

    always_comb begin
        d_req   = dREN | dWEN;
        grant_d = d_req && (!iREN || !last_grant);
        hit     = (ramstate == ACCESS);
        finish  = hit || (ramstate == ERROR) || (cnt == CNT_LAST);
    end

    // RAM-facing outputs are the latched request itself, so they cannot move during BUSY.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            last_grant <= 1'b0;
            cur_grant  <= 1'b0;
            cnt        <= '0;
            iload      <= '0;
            dload      <= '0;
            idone      <= 1'b0;
            ddone      <= 1'b0;
            ierr       <= 1'b0;
            derr       <= 1'b0;
            err_sticky <= 1'b0;
            ramREN     <= 1'b0;
            ramWEN     <= 1'b0;
            ramaddr    <= '0;
            ramstore   <= '0;
        end else begin
            idone <= 1'b0;
            ddone <= 1'b0;
            ierr  <= 1'b0;
            derr  <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (grant_d) begin
                        cur_grant <= 1'b1;
                        if (dREN && dWEN) begin
                            state      <= RESP;
                            ddone      <= 1'b1;
                            derr       <= 1'b1;
                            dload      <= BAD;
                            err_sticky <= 1'b1;
                        end else begin
                            state    <= BUSY_D;
                            ramREN   <= dREN;
                            ramWEN   <= dWEN;
                            ramaddr  <= daddr;
                            ramstore <= dWEN ? dstore : '0;
                        end
                    end else if (iREN) begin
                        cur_grant <= 1'b0;
                        state     <= BUSY_I;
                        ramREN    <= 1'b1;
                        ramWEN    <= 1'b0;
                        ramaddr   <= iaddr;
                        ramstore  <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    cnt <= cnt + 32'd1;
                    if (finish) begin
                        state    <= RESP;
                        ramREN   <= 1'b0;
                        ramWEN   <= 1'b0;
                        ramaddr  <= '0;
                        ramstore <= '0;
                        if (!hit)
                            err_sticky <= 1'b1;
                        if (state == BUSY_I) begin
                            idone <= 1'b1;
                            ierr  <= !hit;
                            iload <= hit ? ramload : BAD;
                        end else begin
                            ddone <= 1'b1;
                            derr  <= !hit;
                            dload <= !hit ? BAD : (ramWEN ? '0 : ramload);
                        end
                    end
                end
                RESP: begin
                    last_grant <= cur_grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_requester.sv
// Bench for ram_requester: RAM model with restartable latency, vector table, directed corners, random traffic.
`timescale 1ns/1ps
module tb_ram_requester;
    import cpu_types_pkg::*;

    localparam word_t BADV = 32'hBAD1BAD1;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    // main instance (TIMEOUT 64)
    logic      iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    word_t     iaddr = '0, daddr = '0, dstore = '0;
    word_t     iload, dload, ramaddr, ramstore;
    logic      idone, ddone, ierr, derr, err_sticky, ramREN, ramWEN;
    word_t     ramload = '0;
    ramstate_t ramstate = FREE;

    // timeout instance (TIMEOUT 8) against a RAM stuck in BUSY
    logic      t_iREN = 1'b0, t_dREN = 1'b0, t_dWEN = 1'b0;
    word_t     t_iaddr = '0, t_daddr = '0, t_dstore = '0;
    word_t     t_iload, t_dload, t_ramaddr, t_ramstore;
    logic      t_idone, t_ddone, t_ierr, t_derr, t_err_sticky, t_ramREN, t_ramWEN;
    word_t     t_ramload = '0;
    ramstate_t t_ramstate = BUSY;

    ram_requester u_dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .iload(iload), .dload(dload), .idone(idone),
        .ddone(ddone), .ierr(ierr), .derr(derr), .err_sticky(err_sticky),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    ram_requester #(.TIMEOUT(8)) u_dut_to (
        .CLK(CLK), .RST(RST), .iREN(t_iREN), .iaddr(t_iaddr), .dREN(t_dREN), .dWEN(t_dWEN),
        .daddr(t_daddr), .dstore(t_dstore), .iload(t_iload), .dload(t_dload), .idone(t_idone),
        .ddone(t_ddone), .ierr(t_ierr), .derr(t_derr), .err_sticky(t_err_sticky),
        .ramREN(t_ramREN), .ramWEN(t_ramWEN), .ramaddr(t_ramaddr), .ramstore(t_ramstore),
        .ramload(t_ramload), .ramstate(t_ramstate)
    );

    // RAM model: ACCESS after lat+1 stable enabled cycles; any addr/enable change restarts the count.
    word_t mem [word_t];
    word_t ref_mem [word_t];
    int    lat = 0, mode = 0;   // mode 0 normal, 2 ERROR
    int    rcnt = 0, off_run = 2, stab_viol = 0, gap_viol = 0;
    logic  m_en, p_en = 1'b0, p_ren = 1'b0, p_wen = 1'b0;
    word_t p_addr = '0, p_store = '0;
    logic  last_d = 1'b0;       // which port completed last (reset -> I)

    always @(negedge CLK) begin
        m_en = ramREN | ramWEN;
        if (m_en && p_en && (ramREN != p_ren || ramWEN != p_wen || ramaddr != p_addr || ramstore != p_store))
            stab_viol++;
        if (m_en) begin
            if (!p_en && off_run < 2) gap_viol++;
            off_run = 0;
            rcnt = (p_en && ramREN == p_ren && ramWEN == p_wen && ramaddr == p_addr) ? rcnt + 1 : 0;
            if (mode == 2) begin
                ramstate = ERROR;
                ramload  = '0;
            end else if (rcnt >= lat + 1) begin
                ramstate = ACCESS;
                ramload  = (ramREN && mem.exists(ramaddr)) ? mem[ramaddr] : '0;
                if (ramWEN) mem[ramaddr] = ramstore;
            end else begin
                ramstate = BUSY;
                ramload  = '0;
            end
        end else begin
            off_run++;
            rcnt     = 0;
            ramstate = FREE;
            ramload  = '0;
        end
        if (RST) begin
            off_run = 2;
            last_d  = 1'b0;
        end else if (idone) last_d = 1'b0;
        else if (ddone) last_d = 1'b1;
        p_en = m_en; p_ren = ramREN; p_wen = ramWEN; p_addr = ramaddr; p_store = ramstore;
    end

    int n_pass = 0, n_tot = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, got, exp);
    endtask

    function automatic word_t ref_rd(input word_t a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    typedef struct {
        logic ir, dr, dw;
        word_t addr, data;
        int lat, mode;
        logic exp_d;
        int exp_cyc;
        word_t exp_load;
        logic exp_err;
        int exp_en;
    } vec_t;

    vec_t tbl [8];

    // Request at cycle 0 (from IDLE); count cycles to done and enabled cycles on the way.
    task automatic do_txn(input vec_t v, input string tag);
        int k, en_cnt;
        logic got_d, got_err;
        word_t got_load;
        lat = v.lat; mode = v.mode;
        iREN = v.ir; iaddr = v.addr; dREN = v.dr; dWEN = v.dw; daddr = v.addr; dstore = v.data;
        k = 0; en_cnt = 0; got_d = 1'b0; got_err = 1'b0; got_load = '0;
        while (k < 100) begin
            @(posedge CLK); #1;
            k++;
            if (ramREN | ramWEN) en_cnt++;
            if (idone | ddone) begin
                got_d    = ddone;
                got_load = ddone ? dload : iload;
                got_err  = ddone ? derr : ierr;
                break;
            end
        end
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        check({tag, " done cycle"}, k, v.exp_cyc);
        check1({tag, " port"}, got_d, v.exp_d);
        check({tag, " load"}, got_load, v.exp_load);
        check1({tag, " err"}, got_err, v.exp_err);
        check({tag, " enabled cycles"}, en_cnt, v.exp_en);
        @(posedge CLK); #1;
        check1({tag, " single-cycle pulse"}, idone | ddone, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] order;
        int n, k;
        logic early;

        mem[32'h40]     = 32'h1234ABCD;
        ref_mem[32'h40] = 32'h1234ABCD;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h40,  32'h0,        15, 0, 1'b0, 18, 32'h1234ABCD, 1'b0, 17};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 15, 0, 1'b1, 18, 32'h0,        1'b0, 17};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 32'h100, 32'h0,        15, 0, 1'b1, 18, 32'hDEADBEEF, 1'b0, 17};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h100, 32'h5,        15, 0, 1'b1, 1,  BADV,         1'b1, 0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0,        0,  0, 1'b0, 3,  32'hDEADBEEF, 1'b0, 2};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 32'h44,  32'h0BADF00D, 4,  0, 1'b1, 7,  32'h0,        1'b0, 6};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 32'h44,  32'h0,        2,  0, 1'b0, 5,  32'h0BADF00D, 1'b0, 4};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 32'h40,  32'h0,        3,  2, 1'b1, 2,  BADV,         1'b1, 1};

        // reset values
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("reset flags", 32'({idone, ddone, ierr, derr, err_sticky, ramREN, ramWEN}), 32'h0);
        check("reset ramaddr", ramaddr, 32'h0);
        check("reset ramstore", ramstore, 32'h0);
        check("reset loads", iload | dload, 32'h0);
        check("reset timeout inst flags", 32'({t_idone, t_ddone, t_err_sticky, t_ramREN, t_ramWEN}), 32'h0);
        RST = 1'b0;

        // both ports held from reset: strict alternation starting with D
        lat = 2; mode = 0;
        iREN = 1'b1; iaddr = 32'h40; dREN = 1'b1; daddr = 32'h40;
        order = '0; n = 0;
        for (int c = 0; c < 200 && n < 4; c++) begin
            @(posedge CLK); #1;
            if (idone || ddone) begin
                order[n] = ddone;
                n++;
            end
        end
        iREN = 1'b0; dREN = 1'b0;
        check("alternation order", 32'(order), 32'h5);
        @(posedge CLK); #1;

        for (int i = 0; i < 8; i++) do_txn(tbl[i], $sformatf("vec%0d", i));
        mode = 0;
        check1("err_sticky after errors", err_sticky, 1'b1);

        // timeout instance: D read then I read against a stuck RAM
        t_dREN = 1'b1; t_daddr = 32'h300;
        k = 0;
        while (k < 40) begin
            @(posedge CLK); #1;
            k++;
            if (t_ddone) break;
        end
        t_dREN = 1'b0;
        check("timeout D done cycle", k, 9);
        check1("timeout derr", t_derr, 1'b1);
        check("timeout dload", t_dload, BADV);
        check1("timeout err_sticky", t_err_sticky, 1'b1);
        @(posedge CLK); #1;
        t_iREN = 1'b1; t_iaddr = 32'h304;
        k = 0;
        while (k < 40) begin
            @(posedge CLK); #1;
            k++;
            if (t_idone) break;
        end
        t_iREN = 1'b0;
        check("timeout I done cycle", k, 9);
        check1("timeout ierr", t_ierr, 1'b1);
        check("timeout iload", t_iload, BADV);
        repeat (5) @(posedge CLK);
        #1;
        check1("err_sticky holds", t_err_sticky, 1'b1);

        // reset in cycle 5 of an I read, then the held request is reissued
        lat = 15;
        iREN = 1'b1; iaddr = 32'h40;
        early = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge CLK); #1;
            early |= idone;
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        check("mid reset flags", 32'({idone, ddone, ierr, derr, err_sticky, ramREN, ramWEN, early}), 32'h0);
        check("mid reset ramaddr", ramaddr, 32'h0);
        check1("mid reset clears timeout sticky", t_err_sticky, 1'b0);
        RST = 1'b0;
        k = 0;
        while (k < 100) begin
            @(posedge CLK); #1;
            k++;
            if (idone) break;
        end
        iREN = 1'b0;
        check("reissued done cycle", k, 18);
        check("reissued iload", iload, 32'h1234ABCD);

        // random traffic against the shadow memory and the alternation rule
        for (int t = 0; t < 80; t++) begin
            int sel, dop;
            logic i_p, d_p, both, exp_first_d, first_set, first_d;
            word_t ia, da, ds;
            @(posedge CLK); #1;
            sel  = int'($urandom_range(1, 3));
            dop  = int'($urandom_range(0, 9));
            lat  = int'($urandom_range(0, 5));
            ia   = 32'h200 + 32'($urandom_range(0, 7)) * 32'd4;
            da   = 32'h200 + 32'($urandom_range(0, 7)) * 32'd4;
            ds   = $urandom;
            i_p  = sel[0];
            d_p  = sel[1];
            both = i_p && d_p;
            exp_first_d = !last_d;
            iREN = i_p; iaddr = ia;
            dREN = d_p && (dop == 0 || dop >= 5);
            dWEN = d_p && dop <= 4;
            daddr = da; dstore = ds;
            first_set = 1'b0; first_d = 1'b0;
            for (int c = 0; c < 200 && (i_p || d_p); c++) begin
                @(posedge CLK); #1;
                if (idone) begin
                    check("rand iload", iload, ref_rd(ia));
                    check1("rand ierr", ierr, 1'b0);
                    iREN = 1'b0; i_p = 1'b0;
                    if (!first_set) begin first_set = 1'b1; first_d = 1'b0; end
                end
                if (ddone) begin
                    if (dop == 0) begin
                        check("rand illegal dload", dload, BADV);
                        check1("rand illegal derr", derr, 1'b1);
                    end else if (dop <= 4) begin
                        check("rand write dload", dload, 32'h0);
                        check1("rand write derr", derr, 1'b0);
                        ref_mem[da] = ds;
                    end else begin
                        check("rand dload", dload, ref_rd(da));
                        check1("rand derr", derr, 1'b0);
                    end
                    dREN = 1'b0; dWEN = 1'b0; d_p = 1'b0;
                    if (!first_set) begin first_set = 1'b1; first_d = 1'b1; end
                end
            end
            iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
            check("rand completion", 32'({i_p, d_p}), 32'h0);
            if (both) check1("rand arbitration", first_d, exp_first_d);
        end

        repeat (3) @(posedge CLK);
        #1;
        check("ram signal stability", stab_viol, 0);
        check("enable gap between accesses", gap_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
